// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the 640x480@60 Hz display path.
// The game geometry uses the same screen size. The default timing is
// reproduced here so that the blocks stay consistent with each other.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The asserted level of hsync/vsync. A value of 0 means the syncs are active-low.
  localparam logic SYNC_ACTIVE = 1'b0;

  // This is the number of extra pix_ce stages on the syncs when the sync pipe is built.
  localparam int SYNC_DELAY = 2;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis. It provides the terminal count, plus the
// active-region and sync-window flags for the value the counter is about to take.
// Those flags are taken from the next value rather than the current one. This lets
// the registered syncs line up with the registered counter in the same cycle.
module vga_axis_counter import vga_timing_gen_pkg::*; #(
  parameter int TOTAL   = 800,
  parameter int ACTIVE  = 640,
  parameter int SYNC_LO = 656,
  parameter int SYNC_HI = 752
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc,
  output logic             active_nxt,
  output logic             sync_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S_LO = CNT_W'(SYNC_LO);
  localparam logic [CNT_W-1:0] S_HI = CNT_W'(SYNC_HI);

  assign tc = (cnt == LAST);

  // Next value: hold, increment, or wrap to zero at the terminal count
  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = tc ? '0 : cnt + 1'b1;
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign active_nxt = (cnt_nxt < ACT);
  assign sync_nxt   = (cnt_nxt >= S_LO) && (cnt_nxt < S_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator. It produces the pixel coordinates, hsync/vsync,
// video_on and a per-frame tick, all of which are registered.
// Optional macro VGA_SYNC_PIPE_EN: when it is defined, hsync/vsync/video_on are
// delayed by SYNC_DELAY extra pix_ce stages. This matches the downstream colour
// pipeline. The coordinates and frame_tick are not delayed.
module vga_timing_gen #(
  parameter int   H_ACTIVE    = vga_timing_gen_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_timing_gen_pkg::H_FP,
  parameter int   H_SYNC      = vga_timing_gen_pkg::H_SYNC,
  parameter int   H_BP        = vga_timing_gen_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_timing_gen_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_timing_gen_pkg::V_FP,
  parameter int   V_SYNC      = vga_timing_gen_pkg::V_SYNC,
  parameter int   V_BP        = vga_timing_gen_pkg::V_BP,
  parameter logic SYNC_ACTIVE = vga_timing_gen_pkg::SYNC_ACTIVE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pix_ce,
  output logic [vga_timing_gen_pkg::CNT_W-1:0] xpix,
  output logic [vga_timing_gen_pkg::CNT_W-1:0] ypix,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               video_on,
  output logic                               frame_tick
);
  import vga_timing_gen_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] TICK_LINE = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_tc;
  logic             h_act_nxt, h_sync_nxt, v_act_nxt, v_sync_nxt;
  logic             hs_r, vs_r, von_r;

  vga_axis_counter #(
    .TOTAL  (H_TOTAL),
    .ACTIVE (H_ACTIVE),
    .SYNC_LO(H_ACTIVE + H_FP),
    .SYNC_HI(H_ACTIVE + H_FP + H_SYNC)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_ce),
    .cnt       (xpix),
    .cnt_nxt   (h_nxt),
    .tc        (h_tc),
    .active_nxt(h_act_nxt),
    .sync_nxt  (h_sync_nxt)
  );

  // The line counter steps only when the pixel counter wraps. The frame wraps
  // on its own at the last pixel of the last line.
  vga_axis_counter #(
    .TOTAL  (V_TOTAL),
    .ACTIVE (V_ACTIVE),
    .SYNC_LO(V_ACTIVE + V_FP),
    .SYNC_HI(V_ACTIVE + V_FP + V_SYNC)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_ce & h_tc),
    .cnt       (ypix),
    .cnt_nxt   (v_nxt),
    .tc        (),
    .active_nxt(v_act_nxt),
    .sync_nxt  (v_sync_nxt)
  );

  // Syncs and active flag are registered from the next coordinates, so they describe the current pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r  <= ~SYNC_ACTIVE;
      vs_r  <= ~SYNC_ACTIVE;
      von_r <= 1'b1;
    end else if (pix_ce) begin
      hs_r  <= h_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_r  <= v_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      von_r <= h_act_nxt & v_act_nxt;
    end
  end

  // One-cycle pulse when the raster enters (0, V_ACTIVE), which is the start of vertical blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_tick <= 1'b0;
    else        frame_tick <= pix_ce && (h_nxt == '0) && (v_nxt == TICK_LINE);
  end

`ifdef VGA_SYNC_PIPE_EN
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, von_pipe;

  // Extra delay stages advanced by pix_ce. Reset fills them with inactive levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe  <= {SYNC_DELAY{~SYNC_ACTIVE}};
      vs_pipe  <= {SYNC_DELAY{~SYNC_ACTIVE}};
      von_pipe <= '0;
    end else if (pix_ce) begin
      hs_pipe  <= {hs_pipe[SYNC_DELAY-2:0],  hs_r};
      vs_pipe  <= {vs_pipe[SYNC_DELAY-2:0],  vs_r};
      von_pipe <= {von_pipe[SYNC_DELAY-2:0], von_r};
    end
  end

  assign hsync    = hs_pipe[SYNC_DELAY-1];
  assign vsync    = vs_pipe[SYNC_DELAY-1];
  assign video_on = von_pipe[SYNC_DELAY-1];
`else
  assign hsync    = hs_r;
  assign vsync    = vs_r;
  assign video_on = von_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. It drives two instances from the same stimulus.
// The first uses the full 640x480 timing and exercises line-level behaviour.
// The second uses a shrunken raster, so that whole frames, frame ticks and the
// last-pixel wrap fit in a short run.
// The reference model tracks a linear pixel index and derives the expected
// outputs from it using plain arithmetic.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       tick;
  } obs_t;

  // Timing for the small instance
  localparam int S_HA = 16, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VA = 12, S_VF = 3, S_VS = 2, S_VB = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;

  logic [9:0] xl, yl, xs, ys;
  logic hsl, vsl, vonl, tkl, hss, vss, vons, tks;

  int n_checks = 0;
  int n_pass   = 0;
  int ticks_seen = 0, ticks_exp = 0;
  int idx_l = 0, idx_s = 0;
  obs_t q_l[$];
  obs_t q_s[$];

  always #5 clk = ~clk;

  vga_timing_gen dut_l (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .xpix(xl), .ypix(yl), .hsync(hsl), .vsync(vsl),
    .video_on(vonl), .frame_tick(tkl)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .xpix(xs), .ypix(ys), .hsync(hss), .vsync(vss),
    .video_on(vons), .frame_tick(tks)
  );

  // Expected outputs for a given pixel index, with active-low syncs
  function automatic obs_t ref_px(int idx, bit tk, int ha, int hf, int hsw, int va, int vf, int vsw, int ht);
    obs_t o;
    int x, y;
    x = idx % ht;
    y = idx / ht;
    o.x    = 10'(x);
    o.y    = 10'(y);
    o.hs   = !(x >= ha + hf && x < ha + hf + hsw);
    o.vs   = !(y >= va + vf && y < va + vf + vsw);
    o.von  = (x < ha) && (y < va);
    o.tick = tk;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b exp x=%0d y=%0d hs=%b vs=%b von=%b tick=%b @%0t",
                  nm, got.x, got.y, got.hs, got.vs, got.von, got.tick,
                  exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.tick, $time);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", nm, got, exp);
  endtask

  // One clock: apply pix_ce, advance the model at the edge, and queue what the DUT should show
  task automatic step(input bit ce);
    int ht_l, vt_l, ht_s, vt_s;
    bit tk_l, tk_s;
    ht_l = 800; vt_l = 525;
    ht_s = S_HA + S_HF + S_HS + S_HB;
    vt_s = S_VA + S_VF + S_VS + S_VB;
    pix_ce = ce;
    @(posedge clk);
    if (ce) begin
      idx_l = (idx_l + 1) % (ht_l * vt_l);
      idx_s = (idx_s + 1) % (ht_s * vt_s);
    end
    tk_l = ce && (idx_l == 480 * ht_l);
    tk_s = ce && (idx_s == S_VA * ht_s);
    q_l.push_back(ref_px(idx_l, tk_l, 640, 16, 96, 480, 10, 2, ht_l));
    q_s.push_back(ref_px(idx_s, tk_s, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, ht_s));
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    obs_t r;
    r = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, tick: 1'b0};
    cmp({nm, "_l"}, {xl, yl, hsl, vsl, vonl, tkl}, r);
    cmp({nm, "_s"}, {xs, ys, hss, vss, vons, tks}, r);
  endtask

  // Monitor: every output cycle, pop the expected value and compare it with the DUT
  always @(negedge clk) begin
    obs_t e;
    if (q_l.size() > 0) begin
      e = q_l.pop_front();
      cmp("scb_large", {xl, yl, hsl, vsl, vonl, tkl}, e);
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      cmp("scb_small", {xs, ys, hss, vss, vons, tks}, e);
      ticks_seen += int'(tks);
      ticks_exp  += int'(e.tick);
    end
  end

  initial begin
    #23;
    chk_reset_vals("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Check that outputs hold with pix_ce low, then run continuously through a line wrap and small-frame wraps
    repeat (3) step(1'b0);
    repeat (900) step(1'b1);

    // Half-rate pixel clock
    for (int i = 0; i < 1700; i++) step(i[0] == 1'b0);

    // Random enable pattern
    repeat (3000) step($urandom_range(0, 3) != 0);

    // Assert reset mid-frame, away from any clock edge
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_hold");
    #2 rst_n = 1'b1;
    idx_l = 0;
    idx_s = 0;
    @(negedge clk);

    repeat (1500) step(1'b1);

    repeat (2) @(negedge clk);
    chk_int("queue_drain", q_l.size() + q_s.size(), 0);
    chk_int("small_tick_count", ticks_seen, ticks_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
